// File: rtl/csi_mode_parser.sv
// CSI mode-sequence parser: turns ESC [ (?) Pn ; Pn ... h/l byte streams into
// INIT_PN / EMIT_PN / SET/RESET(MODE|DEC) pulses and forwards printable bytes.
module csi_mode_parser #(
  parameter int MAX_PARAMS = 16,
  parameter int PN_MAX     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       commandReady,
  output logic [2:0] commandType,
  output logic [7:0] paramt,
  output logic       print_valid,
  output logic [7:0] print_char
);

  localparam logic [2:0] INIT_PN   = 3'd0;
  localparam logic [2:0] EMIT_PN   = 3'd1;
  localparam logic [2:0] SETMODE   = 3'd2;
  localparam logic [2:0] RESETMODE = 3'd3;
  localparam logic [2:0] SETDEC    = 3'd4;
  localparam logic [2:0] RESETDEC  = 3'd5;

  localparam int          PCW       = $clog2(MAX_PARAMS) + 1;
  localparam logic [11:0] PN_MAX_W  = 12'(PN_MAX);
  localparam logic [PCW-1:0] PC_LAST = PCW'(MAX_PARAMS - 1);

  typedef enum logic [2:0] {
    GROUND     = 3'd0,
    ESCAPE     = 3'd1,
    CSI_ENTRY  = 3'd2,
    CSI_PARAM  = 3'd3,
    CSI_IGNORE = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [7:0]     acc_r, acc_s;
  logic [PCW-1:0] pcount_r, pcount_s;
  logic           dec_r, dec_s;

  logic           cmd_s;
  logic [2:0]     cmd_type_s;
  logic [7:0]     pn_s;
  logic           print_s;
  logic           final_cmd_s;

  logic           accept_s;
  logic           is_digit_s, is_semi_s, is_qmark_s, is_esc_s, is_cancel_s;
  logic           is_c0_s, is_inter_s, is_final_s, is_printable_s, is_bad_param_s;
  logic           is_lbrack_s, is_h_s, is_l_s;
  logic [11:0]    acc_ext_s;
  logic [7:0]     acc_sat_s;
  logic           param_full_s;

  assign accept_s       = char_valid && char_ready;
  assign is_digit_s     = (char_data >= 8'h30) && (char_data <= 8'h39);
  assign is_semi_s      = (char_data == 8'h3B);
  assign is_qmark_s     = (char_data == 8'h3F);
  assign is_esc_s       = (char_data == 8'h1B);
  assign is_cancel_s    = (char_data == 8'h18) || (char_data == 8'h1A);
  assign is_c0_s        = (char_data < 8'h20);
  assign is_inter_s     = (char_data >= 8'h20) && (char_data <= 8'h2F);
  assign is_final_s     = (char_data >= 8'h40) && (char_data <= 8'h7E);
  assign is_printable_s = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign is_bad_param_s = (char_data == 8'h3A) || ((char_data >= 8'h3C) && (char_data <= 8'h3E));
  assign is_lbrack_s    = (char_data == 8'h5B);
  assign is_h_s         = (char_data == 8'h68);
  assign is_l_s         = (char_data == 8'h6C);

  // Widen before saturating so 25 * 10 + 9 style overflow is caught.
  assign acc_ext_s    = ({4'd0, acc_r} * 12'd10) + {8'd0, char_data - 8'h30};
  assign acc_sat_s    = (acc_ext_s > PN_MAX_W) ? PN_MAX_W[7:0] : acc_ext_s[7:0];
  assign param_full_s = (pcount_r >= PC_LAST);
  assign final_cmd_s  = commandReady && (commandType != INIT_PN) && (commandType != EMIT_PN);

  // State, parameter context and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= GROUND;
      acc_r        <= 8'd0;
      pcount_r     <= '0;
      dec_r        <= 1'b0;
      commandReady <= 1'b0;
      commandType  <= INIT_PN;
      paramt       <= 8'd0;
      print_valid  <= 1'b0;
      print_char   <= 8'd0;
      char_ready   <= 1'b1;
    end else begin
      state_r      <= state_s;
      acc_r        <= acc_s;
      pcount_r     <= pcount_s;
      dec_r        <= dec_s;
      commandReady <= cmd_s;
      commandType  <= cmd_type_s;
      paramt       <= pn_s;
      print_valid  <= print_s;
      print_char   <= print_s ? char_data : 8'd0;
      // One stall cycle after a mode-changing strobe lets downstream commit it.
      char_ready   <= !final_cmd_s;
    end
  end

  // Next-state and parameter-context update for an accepted byte.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    pcount_s = pcount_r;
    dec_s    = dec_r;
    if (accept_s) begin
      case (state_r)
        GROUND: begin
          if (is_esc_s) state_s = ESCAPE;
          else          state_s = GROUND;
        end
        ESCAPE: begin
          if (is_lbrack_s) begin
            state_s  = CSI_ENTRY;
            acc_s    = 8'd0;
            pcount_s = '0;
            dec_s    = 1'b0;
          end else if (is_esc_s) begin
            state_s = ESCAPE;
          end else begin
            state_s = GROUND;
          end
        end
        CSI_ENTRY, CSI_PARAM: begin
          if (is_cancel_s) begin
            state_s = GROUND;
          end else if (is_esc_s) begin
            state_s = ESCAPE;
          end else if (is_c0_s) begin
            state_s = state_r;
          end else if (is_digit_s) begin
            acc_s   = acc_sat_s;
            state_s = CSI_PARAM;
          end else if (is_semi_s) begin
            acc_s   = 8'd0;
            state_s = CSI_PARAM;
            if (!param_full_s) pcount_s = pcount_r + PCW'(1);
            else               pcount_s = pcount_r;
          end else if (is_qmark_s && (state_r == CSI_ENTRY)) begin
            dec_s   = 1'b1;
            state_s = CSI_ENTRY;
          end else if (is_qmark_s || is_bad_param_s || is_inter_s) begin
            state_s = CSI_IGNORE;
          end else if (is_final_s) begin
            state_s = GROUND;
          end else begin
            state_s = state_r;
          end
        end
        CSI_IGNORE: begin
          if (is_final_s || is_cancel_s) state_s = GROUND;
          else if (is_esc_s)             state_s = ESCAPE;
          else                           state_s = CSI_IGNORE;
        end
        default: state_s = GROUND;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Strobe generation for an accepted byte; registered one cycle later.
  always_comb begin
    cmd_s      = 1'b0;
    cmd_type_s = INIT_PN;
    pn_s       = 8'd0;
    print_s    = 1'b0;
    if (accept_s) begin
      case (state_r)
        GROUND: begin
          print_s = is_printable_s;
        end
        ESCAPE: begin
          cmd_s = is_lbrack_s;
        end
        CSI_ENTRY, CSI_PARAM: begin
          if (is_semi_s && !param_full_s) begin
            cmd_s      = 1'b1;
            cmd_type_s = EMIT_PN;
            pn_s       = acc_r;
          end else if (is_h_s) begin
            cmd_s      = 1'b1;
            cmd_type_s = dec_r ? SETDEC : SETMODE;
            pn_s       = acc_r;
          end else if (is_l_s) begin
            cmd_s      = 1'b1;
            cmd_type_s = dec_r ? RESETDEC : RESETMODE;
            pn_s       = acc_r;
          end else begin
            cmd_s = 1'b0;
          end
        end
        default: begin
          cmd_s   = 1'b0;
          print_s = 1'b0;
        end
      endcase
    end else begin
      cmd_s = 1'b0;
    end
  end

endmodule
